// File: rtl/counter_sequencer_pkg.sv
// Shared constants and state encoding for the interval sequencer.
package counter_sequencer_pkg;

  localparam int unsigned WIDTH_DEF      = 8;
  localparam int unsigned PRESCALE_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/en_up_counter.sv
// Synchronous up-counter with clear (priority) and enable; wrap/hold decided by the caller.
module en_up_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= r_q + WIDTH'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/counter_sequencer.sv
// Programmable interval controller: latches a config, then steps a counter through
// prescaled intervals, emitting a terminal tick and a done handshake.
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [WIDTH-1:0]      cfg_limit,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  input  logic                  cfg_periodic,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  done_ack,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  tick,
  output logic                  done
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WIDTH-1:0]      r_limit;
  logic [PRESCALE_W-1:0] r_prescale;
  logic                  r_periodic;
  logic                  r_tick;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_cfg_ready;

  logic                  w_tick_nxt;
  logic                  w_cnt_en;
  logic                  w_cnt_clr;
  logic                  w_psc_en;
  logic                  w_psc_clr;
  logic                  w_cfg_hs;
  logic                  w_step;
  logic                  w_at_limit;
  logic [WIDTH-1:0]      w_cnt_q;
  logic [PRESCALE_W-1:0] w_psc_q;

  assign w_cfg_hs   = cfg_valid && r_cfg_ready;
  assign w_step     = (w_psc_q == r_prescale);
  assign w_at_limit = (w_cnt_q == r_limit);

  // Next-state and counter control; stop outranks terminal events and done_ack.
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = 1'b0;
    w_cnt_en    = 1'b0;
    w_cnt_clr   = 1'b0;
    w_psc_en    = 1'b0;
    w_psc_clr   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
          w_cnt_clr   = 1'b1;
          w_psc_clr   = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          w_state_nxt = IDLE;
          w_cnt_clr   = 1'b1;
          w_psc_clr   = 1'b1;
        end else if (w_step) begin
          w_psc_clr = 1'b1;
          if (!w_at_limit) begin
            w_cnt_en = 1'b1;
          end else begin
            w_tick_nxt = 1'b1;
            if (r_periodic) begin
              w_cnt_clr = 1'b1;
            end else begin
              w_state_nxt = DONE;
            end
          end
        end else begin
          w_psc_en = 1'b1;
        end
      end
      DONE: begin
        if (stop) begin
          w_state_nxt = IDLE;
          w_cnt_clr   = 1'b1;
          w_psc_clr   = 1'b1;
        end else if (done_ack) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, registered status outputs and the config latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_tick      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_ready <= 1'b1;
      r_limit     <= '0;
      r_prescale  <= '0;
      r_periodic  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tick      <= w_tick_nxt;
      r_busy      <= (w_state_nxt == RUN);
      r_done      <= (w_state_nxt == DONE);
      r_cfg_ready <= (w_state_nxt == IDLE);
      if (w_cfg_hs) begin
        r_limit    <= cfg_limit;
        r_prescale <= cfg_prescale;
        r_periodic <= cfg_periodic;
      end
    end
  end

  en_up_counter #(.WIDTH(WIDTH)) u_count (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_cnt_en),
    .clr   (w_cnt_clr),
    .q     (w_cnt_q)
  );

  en_up_counter #(.WIDTH(PRESCALE_W)) u_prescale (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_psc_en),
    .clr   (w_psc_clr),
    .q     (w_psc_q)
  );

  assign count     = w_cnt_q;
  assign busy      = r_busy;
  assign tick      = r_tick;
  assign done      = r_done;
  assign cfg_ready = r_cfg_ready;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with hand-computed expectations.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_limit;
  logic [3:0] cfg_prescale;
  logic       cfg_periodic;
  logic       start;
  logic       stop;
  logic       done_ack;
  logic [7:0] count;
  logic       busy;
  logic       tick;
  logic       done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(8), .PRESCALE_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_limit    (cfg_limit),
    .cfg_prescale (cfg_prescale),
    .cfg_periodic (cfg_periodic),
    .start        (start),
    .stop         (stop),
    .done_ack     (done_ack),
    .count        (count),
    .busy         (busy),
    .tick         (tick),
    .done         (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [7:0] lim, input logic [3:0] psc, input logic per);
    cfg_valid = 1'b1; cfg_limit = lim; cfg_prescale = psc; cfg_periodic = per;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_limit = '0; cfg_prescale = '0;
    cfg_periodic = 1'b0; start = 1'b0; stop = 1'b0; done_ack = 1'b0;
    #12;
    check("rst_count", 32'(count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(cfg_ready), 1);
    check("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    step();

    // periodic, limit 3, no prescale
    do_cfg(8'd3, 4'd0, 1'b1);
    do_start();
    check("per_c0", 32'(count), 0);
    check("per_busy0", 32'(busy), 1);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("per_count", 32'(count), 32'(k % 4));
      check("per_tick", 32'(tick), (k % 4 == 0) ? 1 : 0);
    end
    check("per_busy", 32'(busy), 1);
    do_stop();
    check("per_stop_count", 32'(count), 0);
    check("per_stop_busy", 32'(busy), 0);
    check("per_stop_ready", 32'(cfg_ready), 1);

    // one-shot, limit 2, prescale 2: terminal 9 cycles after start
    do_cfg(8'd2, 4'd2, 1'b0);
    do_start();
    for (int k = 1; k <= 9; k++) begin
      step();
      check("os_count", 32'(count), (k / 3 > 2) ? 2 : 32'(k / 3));
      check("os_tick", 32'(tick), (k == 9) ? 1 : 0);
      check("os_done", 32'(done), (k == 9) ? 1 : 0);
    end
    check("os_busy", 32'(busy), 0);
    step();
    check("os_hold_tick", 32'(tick), 0);
    check("os_hold_done", 32'(done), 1);
    check("os_hold_count", 32'(count), 2);
    done_ack = 1'b1;
    step();
    done_ack = 1'b0;
    check("os_ack_done", 32'(done), 0);
    check("os_ack_ready", 32'(cfg_ready), 1);
    check("os_ack_count", 32'(count), 2);

    // stop on the terminal step wins
    do_cfg(8'd2, 4'd0, 1'b0);
    do_start();
    step();
    step();
    check("st_pre_count", 32'(count), 2);
    do_stop();
    check("st_count", 32'(count), 0);
    check("st_tick", 32'(tick), 0);
    check("st_done", 32'(done), 0);
    check("st_ready", 32'(cfg_ready), 1);
    step();
    check("st_tick2", 32'(tick), 0);
    check("st_done2", 32'(done), 0);

    // config and start together: new limit 1 governs, not the old 5
    do_cfg(8'd5, 4'd0, 1'b1);
    cfg_valid = 1'b1; cfg_limit = 8'd1; cfg_prescale = 4'd0; cfg_periodic = 1'b1;
    start = 1'b1;
    step();
    cfg_valid = 1'b0; start = 1'b0;
    check("cs_c0", 32'(count), 0);
    step();
    check("cs_c1", 32'(count), 1);
    check("cs_t1", 32'(tick), 0);
    step();
    check("cs_c2", 32'(count), 0);
    check("cs_t2", 32'(tick), 1);
    // config offered while running is refused
    cfg_valid = 1'b1; cfg_limit = 8'd3;
    check("run_ready", 32'(cfg_ready), 0);
    step();
    check("run_c3", 32'(count), 1);
    step();
    check("run_c4", 32'(count), 0);
    check("run_t4", 32'(tick), 1);
    cfg_valid = 1'b0;
    do_stop();

    // limit 0, prescale 0: tick every cycle
    do_cfg(8'd0, 4'd0, 1'b1);
    do_start();
    check("z_c0", 32'(tick), 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("z_tick", 32'(tick), 1);
      check("z_count", 32'(count), 0);
    end
    do_stop();
    check("z_stop_tick", 32'(tick), 0);

    // limit 255 wraps after 256 steps
    do_cfg(8'd255, 4'd0, 1'b1);
    do_start();
    repeat (255) step();
    check("max_c255", 32'(count), 255);
    check("max_t255", 32'(tick), 0);
    step();
    check("max_wrap", 32'(count), 0);
    check("max_wrap_tick", 32'(tick), 1);
    step();
    check("max_c1", 32'(count), 1);
    check("max_t1", 32'(tick), 0);

    // asynchronous reset mid-run
    repeat (3) step();
    check("ar_pre", 32'(count), 4);
    rst_n = 1'b0;
    #2;
    check("ar_count", 32'(count), 0);
    check("ar_busy", 32'(busy), 0);
    check("ar_tick", 32'(tick), 0);
    check("ar_done", 32'(done), 0);
    check("ar_ready", 32'(cfg_ready), 1);
    rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
